// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared 16-bit address / 8-bit data system bus.
// It sequences each transfer through IDLE, ACCESS and DONE, with wait states, slave ready, locked bursts and a timeout.
module bus_arbiter #(
    parameter int WAIT_STATES    = 1,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_we,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_we,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_read,
    output logic        bus_write,
    input  logic        bus_ready,
    output logic        owner,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WS_MIN  = CW'(WAIT_STATES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic        lock;
    } mreq_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            lock_flag;
    logic            rr_ptr;
    logic            we_q;
    logic            win;
    logic [1:0]      req;
    logic [1:0]      ack;
    logic [1:0][7:0] rdata;
    mreq_t [1:0]     mreq;

    assign req     = {m1_req, m0_req};
    assign mreq[0] = '{addr: m0_addr, wdata: m0_wdata, we: m0_we, lock: m0_lock};
    assign mreq[1] = '{addr: m1_addr, wdata: m1_wdata, we: m1_we, lock: m1_lock};

    assign m0_ack   = ack[0];
    assign m1_ack   = ack[1];
    assign m0_rdata = rdata[0];
    assign m1_rdata = rdata[1];

    // A stale lock, where the owner has dropped req, falls through to normal arbitration in the same cycle.
    always_comb begin
        win = 1'b0;
        if (lock_flag && req[owner])
            win = owner;
        else if (FIXED_PRIORITY != 0)
            win = ~req[0];
        else if (req[rr_ptr])
            win = rr_ptr;
        else
            win = ~rr_ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lock_flag <= 1'b0;
            rr_ptr    <= 1'b0;
            we_q      <= 1'b0;
            owner     <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner     <= win;
                        lock_flag <= mreq[win].lock;
                        bus_addr  <= mreq[win].addr;
                        bus_wdata <= mreq[win].wdata;
                        we_q      <= mreq[win].we;
                        bus_read  <= ~mreq[win].we;
                        bus_write <= mreq[win].we;
                        cnt       <= '0;
                        state     <= ACCESS;
                    end else if (lock_flag && !req[owner]) begin
                        lock_flag <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Normal completion takes precedence over the timeout on the last allowed cycle.
                    if (cnt >= WS_MIN && bus_ready) begin
                        bus_read   <= 1'b0;
                        bus_write  <= 1'b0;
                        ack[owner] <= 1'b1;
                        if (!we_q)
                            rdata[owner] <= bus_rdata;
                        state <= DONE;
                    end else if (cnt == TO_LAST) begin
                        bus_read   <= 1'b0;
                        bus_write  <= 1'b0;
                        ack[owner] <= 1'b1;
                        err        <= 1'b1;
                        if (!we_q)
                            rdata[owner] <= 8'hFF;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a table of single transfers plus sequences for contention, lock, fixed priority and reset.
// Each master's expected completions sit in a scoreboard queue, and every ack pops one entry.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req = '0, we = '0, lock = '0;
    logic [1:0][15:0] addr = '0;
    logic [1:0][7:0]  wdat = '0;

    logic        d0_m0_ack, d0_m1_ack, d0_read, d0_write, d0_owner, d0_err, d0_ready;
    logic [7:0]  d0_m0_rdata, d0_m1_rdata, d0_wdata, d0_rdata;
    logic [15:0] d0_addr;
    logic        d1_m0_ack, d1_m1_ack, d1_read, d1_write, d1_owner, d1_err;
    logic [7:0]  d1_m0_rdata, d1_m1_rdata, d1_wdata, d1_rdata;
    logic [15:0] d1_addr;

    int  n_cmp = 0, n_err = 0;
    int  run = 0, last_len = 0, dly = 0;
    bit  stuck = 0, sel = 0;

    typedef struct {logic [7:0] rdata; logic err;} exp_t;
    exp_t sb0[$], sb1[$];
    int   ack_log[$];

    function automatic logic [7:0] slave_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7F;
    endfunction

    assign d0_rdata = slave_fn(d0_addr);
    assign d1_rdata = slave_fn(d1_addr);
    assign d0_ready = !stuck && (run > dly);

    bus_arbiter dut0 (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdat[0]), .m0_we(we[0]), .m0_lock(lock[0]),
        .m0_ack(d0_m0_ack), .m0_rdata(d0_m0_rdata),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdat[1]), .m1_we(we[1]), .m1_lock(lock[1]),
        .m1_ack(d0_m1_ack), .m1_rdata(d0_m1_rdata),
        .bus_addr(d0_addr), .bus_wdata(d0_wdata), .bus_rdata(d0_rdata),
        .bus_read(d0_read), .bus_write(d0_write), .bus_ready(d0_ready),
        .owner(d0_owner), .err(d0_err)
    );

    bus_arbiter #(.FIXED_PRIORITY(1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdat[0]), .m0_we(we[0]), .m0_lock(lock[0]),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdat[1]), .m1_we(we[1]), .m1_lock(lock[1]),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .bus_addr(d1_addr), .bus_wdata(d1_wdata), .bus_rdata(d1_rdata),
        .bus_read(d1_read), .bus_write(d1_write), .bus_ready(1'b1),
        .owner(d1_owner), .err(d1_err)
    );

    logic [1:0]      ack_a;
    logic [1:0][7:0] rd_a;
    logic            own_a, err_a;
    assign ack_a = sel ? {d1_m1_ack, d1_m0_ack} : {d0_m1_ack, d0_m0_ack};
    assign rd_a  = sel ? {d1_m1_rdata, d1_m0_rdata} : {d0_m1_rdata, d0_m0_rdata};
    assign own_a = sel ? d1_owner : d0_owner;
    assign err_a = sel ? d1_err : d0_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model for dut0: count strobe cycles, hold ready low for the first dly cycles.
    always @(negedge clk) begin
        if (d0_read || d0_write) begin
            run <= run + 1;
        end else begin
            if (run != 0) last_len <= run;
            run <= 0;
        end
    end

    // Scoreboard: every ack pops the acked master's expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (ack_a == 2'b11) check("dual_ack", 1, 0);
            for (int m = 0; m < 2; m++) begin
                if (ack_a[m]) begin
                    ack_log.push_back(m);
                    if ((m == 0 && sb0.size() == 0) || (m == 1 && sb1.size() == 0)) begin
                        check($sformatf("unexpected_ack_m%0d", m), 1, 0);
                    end else begin
                        e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
                        check($sformatf("rdata_m%0d", m), rd_a[m], e.rdata);
                        check($sformatf("err_m%0d", m), err_a, e.err);
                        check($sformatf("owner_m%0d", m), own_a, m);
                    end
                end
            end
        end
    end

    task automatic xfer(input int m, input bit w, input logic [15:0] a, input logic [7:0] wd,
                        input bit lk, input int d, input bit st, input logic [7:0] erd,
                        input bit eerr, input int eedges, input int elen);
        exp_t e;
        int   edges = 0;
        bit   got = 0;
        e.rdata = erd;
        e.err   = eerr;
        if (m == 0) sb0.push_back(e); else sb1.push_back(e);
        dly = d; stuck = st;
        we[m] = w; addr[m] = a; wdat[m] = wd; lock[m] = lk; req[m] = 1'b1;
        while (!got && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            got = ack_a[m];
        end
        check($sformatf("ack_seen_m%0d", m), got, 1);
        if (eedges >= 0) check($sformatf("latency_m%0d", m), edges, eedges);
        req[m] = 1'b0; lock[m] = 1'b0;
        @(negedge clk);
        if (elen >= 0) check($sformatf("strobe_len_m%0d", m), last_len, elen);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; lock = '0; dly = 0; stuck = 0;
        sb0.delete(); sb1.delete(); ack_log.delete();
        @(negedge clk);
        check("reset_d0", {d0_read, d0_write, d0_addr, d0_wdata, d0_m0_ack, d0_m1_ack, d0_owner, d0_err}, 0);
        check("reset_d1", {d1_read, d1_write, d1_addr, d1_wdata, d1_m0_ack, d1_m1_ack, d1_owner, d1_err}, 0);
        check("reset_rdata", {d0_m0_rdata, d0_m1_rdata, d1_m0_rdata, d1_m1_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_order(input string name, input int exp_order[$]);
        check({name, "_count"}, ack_log.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < ack_log.size(); i++)
            check($sformatf("%s_%0d", name, i), ack_log[i], exp_order[i]);
        ack_log.delete();
    endtask

    typedef struct {
        int m; bit w; logic [15:0] a; logic [7:0] wd; int d; bit st;
        logic [7:0] rd; bit er; int edges; int len;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int  wait_cyc;
        // m, we, addr, wdata, ready-low cycles, stuck, exp rdata, exp err, edges to ack, strobe length
        tbl[0] = '{0, 1'b0, 16'h2005, 8'h00, 0,  1'b0, 8'h5A, 1'b0, 3,  2};
        tbl[1] = '{0, 1'b1, 16'h2005, 8'h33, 0,  1'b0, 8'h5A, 1'b0, 3,  2};
        tbl[2] = '{1, 1'b0, 16'h1234, 8'h00, 0,  1'b0, 8'h59, 1'b0, 3,  2};
        tbl[3] = '{0, 1'b0, 16'h00FF, 8'h00, 0,  1'b0, 8'h80, 1'b0, 3,  2};
        tbl[4] = '{1, 1'b1, 16'hBEEF, 8'h77, 4,  1'b0, 8'h59, 1'b0, 6,  5};
        tbl[5] = '{0, 1'b0, 16'hC3C3, 8'h00, 0,  1'b1, 8'hFF, 1'b1, 16, 15};
        tbl[6] = '{1, 1'b0, 16'h8001, 8'h00, 1,  1'b0, 8'hFE, 1'b0, 3,  2};
        tbl[7] = '{0, 1'b0, 16'h2005, 8'h00, 2,  1'b0, 8'h5A, 1'b0, 4,  3};
        tbl[8] = '{1, 1'b0, 16'h7F10, 8'h00, 14, 1'b0, 8'h10, 1'b0, 16, 15};
        tbl[9] = '{0, 1'b1, 16'h1111, 8'h44, 0,  1'b1, 8'h5A, 1'b1, 16, 15};

        do_reset();
        sel = 0;
        for (int i = 0; i < 10; i++)
            xfer(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].wd, 1'b0, tbl[i].d, tbl[i].st,
                 tbl[i].rd, tbl[i].er, tbl[i].edges, tbl[i].len);
        check("hold_m0_rdata", d0_m0_rdata, 8'h5A);
        check("hold_m1_rdata", d0_m1_rdata, 8'h10);
        check_order("table_order", '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0});

        // Round-robin contention
        do_reset();
        fork
            for (int i = 0; i < 3; i++)
                xfer(0, 1'b0, 16'h1000 + 16'(i), 8'h00, 1'b0, 0, 1'b0, slave_fn(16'h1000 + 16'(i)), 1'b0, -1, -1);
            for (int j = 0; j < 3; j++)
                xfer(1, 1'b0, 16'h2100 + 16'(j), 8'h00, 1'b0, 0, 1'b0, slave_fn(16'h2100 + 16'(j)), 1'b0, -1, -1);
        join
        check_order("rr_order", '{0, 1, 0, 1, 0, 1});

        // Locked burst from m1 holds off m0
        do_reset();
        fork
            for (int i = 0; i < 3; i++)
                xfer(1, 1'b1, 16'h3000 + 16'(i), 8'hA0 + 8'(i), 1'b1, 0, 1'b0, 8'h00, 1'b0, -1, -1);
            begin
                @(negedge clk);
                xfer(0, 1'b0, 16'h2005, 8'h00, 1'b0, 0, 1'b0, 8'h5A, 1'b0, -1, -1);
            end
        join
        check_order("lock_order", '{1, 1, 1, 0});

        // Fixed priority instance
        do_reset();
        sel = 1;
        fork
            for (int i = 0; i < 3; i++)
                xfer(0, 1'b0, 16'h4000 + 16'(i), 8'h00, 1'b0, 0, 1'b0, slave_fn(16'h4000 + 16'(i)), 1'b0, 3, -1);
            xfer(1, 1'b0, 16'h5000, 8'h00, 1'b0, 0, 1'b0, slave_fn(16'h5000), 1'b0, -1, -1);
        join
        check_order("fixed_order", '{0, 0, 0, 1});

        // Reset while a write strobe is active
        do_reset();
        sel = 0;
        we[0] = 1'b1; addr[0] = 16'h4000; wdat[0] = 8'h99; req[0] = 1'b1;
        wait_cyc = 0;
        while (!d0_write && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("write_strobe_seen", d0_write, 1);
        #2 reset = 1'b1;
        #1 check("async_strobe_drop", {d0_write, d0_read, d0_m0_ack, d0_m1_ack}, 0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_reset_idle", {d0_write, d0_read, d0_addr, d0_m0_ack, d0_err}, 0);
        xfer(0, 1'b0, 16'h2005, 8'h00, 1'b0, 0, 1'b0, 8'h5A, 1'b0, 3, 2);
        check_order("post_reset_order", '{0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
